// File: rtl/gray_ptr_decoder.sv
// gray_ptr_decoder
//   Destination-domain Gray pointer decoder for async FIFO pointers. It takes
//   a Gray pointer that has already passed through the 2-FF synchronizer and
//   decodes it to binary in a 2-stage registered pipeline. For each accepted
//   sample it also reports whether the value changed and the modular step
//   since the previous accepted sample.
//
//   Optional feature macro: GRAY_PTR_STEP_CHECK_EN
//     defined   : flags samples where more than one Gray bit toggled relative
//                 to the previous accepted sample, and keeps a saturating
//                 count of such violations.
//     undefined : step_err_o and err_cnt_o are constant 0, and no check logic
//                 is built.
//
// Ports
//   clk_i       destination-domain clock
//   rst_n_i     asynchronous active-low reset
//   gray_i      synchronized Gray-coded pointer
//   gray_vld_i  sample gray_i on this cycle
//   bin_o       decoded binary pointer
//   bin_vld_o   one-cycle pulse; bin_o/chg_o/delta_o/step_err_o are valid
//   chg_o       decoded value differs from the previous accepted value
//   delta_o     (bin_new - bin_prev) mod 2^DATA_WIDTH
//   step_err_o  Gray violation pulse, aligned with bin_vld_o
//   err_cnt_o   saturating violation count
module gray_ptr_decoder #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [DATA_WIDTH-1:0]    gray_i,
  input  logic                     gray_vld_i,
  output logic [DATA_WIDTH-1:0]    bin_o,
  output logic                     bin_vld_o,
  output logic                     chg_o,
  output logic [DATA_WIDTH-1:0]    delta_o,
  output logic                     step_err_o,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

  logic [DATA_WIDTH-1:0] g_q;
  logic                  v_q;
  logic [DATA_WIDTH-1:0] b_dec;
  logic [DATA_WIDTH-1:0] prev_bin;
  logic                  first_seen;

  // Stage 1: capture the sample. g_q holds when no sample is offered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      g_q <= '0;
      v_q <= 1'b0;
    end else begin
      v_q <= gray_vld_i;
      if (gray_vld_i) begin
        g_q <= gray_i;
      end
    end
  end

  // Prefix-XOR decode, MSB down: b[i] = g[W-1] ^ ... ^ g[i].
  always_comb begin
    logic acc;
    b_dec = '0;
    acc   = g_q[DATA_WIDTH-1];
    b_dec[DATA_WIDTH-1] = acc;
    for (int unsigned i = 1; i < DATA_WIDTH; i++) begin
      acc = acc ^ g_q[DATA_WIDTH-1-i];
      b_dec[DATA_WIDTH-1-i] = acc;
    end
  end

  // Stage 2: register decoded value and step information.
  // The first sample after reset reports no change, whatever its value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bin_o      <= '0;
      bin_vld_o  <= 1'b0;
      chg_o      <= 1'b0;
      delta_o    <= '0;
      prev_bin   <= '0;
      first_seen <= 1'b0;
    end else begin
      bin_vld_o <= v_q;
      if (v_q) begin
        bin_o <= b_dec;
        if (first_seen) begin
          delta_o <= b_dec - prev_bin;
          chg_o   <= (b_dec != prev_bin);
        end else begin
          delta_o <= '0;
          chg_o   <= 1'b0;
        end
        prev_bin   <= b_dec;
        first_seen <= 1'b1;
      end
    end
  end

`ifdef GRAY_PTR_STEP_CHECK_EN
  logic [DATA_WIDTH-1:0] prev_gray;
  logic [DATA_WIDTH-1:0] g_diff;
  logic                  step_bad;

  // More than one toggled bit <=> clearing the lowest set bit leaves a
  // nonzero value; equivalent to popcount > 1 without an adder tree.
  always_comb begin
    g_diff   = g_q ^ prev_gray;
    step_bad = first_seen && ((g_diff & (g_diff - DATA_WIDTH'(1))) != '0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_gray  <= '0;
      step_err_o <= 1'b0;
      err_cnt_o  <= '0;
    end else begin
      step_err_o <= v_q && step_bad;
      if (v_q) begin
        prev_gray <= g_q;
        if (step_bad && (err_cnt_o != '1)) begin
          err_cnt_o <= err_cnt_o + ERR_CNT_WIDTH'(1);
        end
      end
    end
  end
`else
  assign step_err_o = 1'b0;
  assign err_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_gray_ptr_decoder.sv
// Self-checking bench for gray_ptr_decoder at DATA_WIDTH=4, ERR_CNT_WIDTH=2.
// Directed table vectors, hand-written reset/latency sequences, and a
// randomized phase checked against a behavioural model.
module tb_gray_ptr_decoder;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;
`ifdef GRAY_PTR_STEP_CHECK_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  gray = '0;
  logic          gvld = 1'b0;
  logic [W-1:0]  bin;
  logic          bvld;
  logic          chg;
  logic [W-1:0]  delta;
  logic          serr;
  logic [CW-1:0] ecnt;

  gray_ptr_decoder #(.DATA_WIDTH(W), .ERR_CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .gray_i(gray), .gray_vld_i(gvld),
    .bin_o(bin), .bin_vld_o(bvld), .chg_o(chg), .delta_o(delta),
    .step_err_o(serr), .err_cnt_o(ecnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          vld;
    logic [W-1:0]  bin;
    logic [W-1:0]  delta;
    logic          chg;
    logic          err;
    logic [CW-1:0] cnt;
  } out_t;

  typedef struct packed {
    logic [W-1:0] gray;
    logic         vld;
    out_t         exp;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic cmp(input string tag, input out_t e);
    chk({tag, ".bin_vld"}, 16'(bvld), 16'(e.vld));
    chk({tag, ".bin"},     16'(bin),  16'(e.bin));
    chk({tag, ".delta"},   16'(delta),16'(e.delta));
    chk({tag, ".chg"},     16'(chg),  16'(e.chg));
    chk({tag, ".step_err"},16'(serr), 16'(e.err));
    chk({tag, ".err_cnt"}, 16'(ecnt), 16'(e.cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] enc(input int unsigned b);
    int unsigned v;
    v = b % (1 << W);
    return W'(v ^ (v >> 1));
  endfunction

  // Decode by searching for the binary value whose Gray code matches.
  function automatic logic [W-1:0] dec(input logic [W-1:0] g);
    for (int unsigned k = 0; k < (1 << W); k++)
      if (enc(k) == g) return W'(k);
    return '0;
  endfunction

  // Behavioural model state
  logic          m_first;
  logic [W-1:0]  m_prev_bin;
  logic [W-1:0]  m_prev_gray;
  out_t          p;

  task automatic m_reset();
    m_first = 1'b0; m_prev_bin = '0; m_prev_gray = '0; p = '0;
  endtask

  // Drive one cycle, check outputs belonging to the previous cycle's sample,
  // then predict the outputs this cycle's sample will produce.
  task automatic rcycle(input string tag, input logic [W-1:0] g, input logic v);
    int unsigned nb, pb;
    gray = g; gvld = v;
    tick();
    cmp(tag, p);
    if (v) begin
      nb = int'(dec(g));
      pb = int'(m_prev_bin);
      p.vld = 1'b1;
      p.bin = W'(nb);
      if (m_first) begin
        p.delta = W'((nb + (1 << W) - pb) % (1 << W));
        p.chg   = (nb != pb);
        p.err   = STEP_EN && ($countones(g ^ m_prev_gray) > 1);
      end else begin
        p.delta = '0; p.chg = 1'b0; p.err = 1'b0;
      end
      if (p.err && p.cnt != {CW{1'b1}}) p.cnt = p.cnt + 1'b1;
      m_first = 1'b1; m_prev_bin = W'(nb); m_prev_gray = g;
    end else begin
      p.vld = 1'b0;
      p.err = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; gvld = 1'b0; gray = '0;
    tick(); tick();
    rst_n = 1'b1;
    m_reset();
  endtask

  vec_t tbl[23];
  int unsigned cur;

  initial begin
    // Table: gray codes 0..15 back-to-back, wrap 15->0, a 2-bit jump,
    // a legal step, repeats and a bubble. exp = outputs for that row's sample.
    for (int unsigned k = 0; k < 16; k++) begin
      tbl[k].gray = enc(k); tbl[k].vld = 1'b1;
      tbl[k].exp = '{vld: 1'b1, bin: W'(k), delta: (k == 0) ? W'(0) : W'(1),
                     chg: (k != 0), err: 1'b0, cnt: '0};
    end
    tbl[16] = '{gray: 4'b0000, vld: 1'b1,
                exp: '{vld: 1'b1, bin: 4'd0, delta: 4'd1, chg: 1'b1, err: 1'b0, cnt: '0}};
    tbl[17] = '{gray: 4'b0011, vld: 1'b1,
                exp: '{vld: 1'b1, bin: 4'd2, delta: 4'd2, chg: 1'b1, err: STEP_EN, cnt: CW'(STEP_EN)}};
    tbl[18] = '{gray: 4'b0010, vld: 1'b1,
                exp: '{vld: 1'b1, bin: 4'd3, delta: 4'd1, chg: 1'b1, err: 1'b0, cnt: CW'(STEP_EN)}};
    tbl[19] = '{gray: 4'b0010, vld: 1'b1,
                exp: '{vld: 1'b1, bin: 4'd3, delta: 4'd0, chg: 1'b0, err: 1'b0, cnt: CW'(STEP_EN)}};
    tbl[20] = '{gray: 4'b0010, vld: 1'b1,
                exp: '{vld: 1'b1, bin: 4'd3, delta: 4'd0, chg: 1'b0, err: 1'b0, cnt: CW'(STEP_EN)}};
    tbl[21] = '{gray: 4'b1111, vld: 1'b0,
                exp: '{vld: 1'b0, bin: 4'd3, delta: 4'd0, chg: 1'b0, err: 1'b0, cnt: CW'(STEP_EN)}};
    tbl[22] = '{gray: 4'b0110, vld: 1'b1,
                exp: '{vld: 1'b1, bin: 4'd4, delta: 4'd1, chg: 1'b1, err: 1'b0, cnt: CW'(STEP_EN)}};

    // Reset state and first-sample latency (gray 0110 -> bin 0100)
    @(negedge clk);
    do_reset();
    cmp("reset", '0);
    gray = 4'b0110; gvld = 1'b1;
    tick();
    cmp("lat_e1", '0);
    gvld = 1'b0; gray = 4'b1111;
    tick();
    cmp("lat_e2", '{vld: 1'b1, bin: 4'd4, delta: 4'd0, chg: 1'b0, err: 1'b0, cnt: '0});
    tick();
    cmp("lat_e3", '{vld: 1'b0, bin: 4'd4, delta: 4'd0, chg: 1'b0, err: 1'b0, cnt: '0});

    // Table-driven sequence
    do_reset();
    for (int unsigned i = 0; i < 23; i++) begin
      gray = tbl[i].gray; gvld = tbl[i].vld;
      tick();
      if (i > 0) cmp($sformatf("tbl%0d", i - 1), tbl[i - 1].exp);
    end
    gvld = 1'b0;
    tick();
    cmp("tbl22", tbl[22].exp);

    // Reset between edges with samples in flight
    gray = enc(9); gvld = 1'b1;
    tick();
    gray = enc(10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 cmp("rst_async", '0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    rcycle("post_rst0", enc(11), 1'b0);
    rcycle("post_rst1", enc(11), 1'b0);
    rcycle("post_rst2", enc(6), 1'b1);
    rcycle("post_rst3", enc(6), 1'b0);
    rcycle("post_rst4", enc(7), 1'b0);

    // Randomized phase against the model
    do_reset();
    cur = 0;
    for (int unsigned n = 0; n < 400; n++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r <= 5)      cur = (cur + 1) % 16;
      else if (r == 8) cur = (cur + 15) % 16;
      else if (r == 9) cur = $urandom_range(0, 15);
      rcycle("rnd", enc(cur), ($urandom_range(0, 3) != 0));
    end
    rcycle("rnd_end", '0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
